// File: rtl/bids22_settle.sv
// Settlement stage for the X/Y/Z auction: snapshots bids at round end, resolves a single
// highest eligible bid, debits the winner and holds the result under a roundOver/res_ack handshake.
module bids22_settle #(
    parameter int unsigned BID_W = 16,
    parameter int unsigned BAL_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             round_end,
    input  logic [BID_W-1:0] X_curr,
    input  logic [BID_W-1:0] Y_curr,
    input  logic [BID_W-1:0] Z_curr,
    input  logic             X_valid,
    input  logic             Y_valid,
    input  logic             Z_valid,
    input  logic [BAL_W-1:0] X_funds,
    input  logic [BAL_W-1:0] Y_funds,
    input  logic [BAL_W-1:0] Z_funds,
    input  logic             res_ack,
    output logic             X_win,
    output logic             Y_win,
    output logic             Z_win,
    output logic [BAL_W-1:0] X_balance,
    output logic [BAL_W-1:0] Y_balance,
    output logic [BAL_W-1:0] Z_balance,
    output logic [BAL_W-1:0] maxBid,
    output logic             roundOver,
    output logic [1:0]       err,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StCompare,
        StSettle,
        StReport
    } state_e;

    state_e state_q, state_d;

    logic [BID_W-1:0] curr_in [3];
    logic [BAL_W-1:0] funds_in [3];
    logic [2:0]       valid_in;

    logic [BID_W-1:0] bid_q [3];
    logic [BAL_W-1:0] fund_q [3];
    logic [2:0]       vld_q;
    logic [2:0]       elig_q;
    logic [2:0]       win1h_q;
    logic [BID_W-1:0] max_q;
    logic             tie_q;
    logic             none_q;
    // ovr_q applies to the round in flight; ovr_pend_q holds a round_end seen in REPORT
    logic             ovr_q;
    logic             ovr_pend_q;

    logic [2:0]       win_q;
    logic [BAL_W-1:0] bal_q [3];
    logic [BAL_W-1:0] max_bid_q;
    logic [1:0]       err_q;

    logic [2:0]       elig_d;
    logic [BID_W-1:0] max_d;
    logic             any_d;
    logic [2:0]       hit_d;
    logic [1:0]       cnt_d;

    assign curr_in[0]  = X_curr;
    assign curr_in[1]  = Y_curr;
    assign curr_in[2]  = Z_curr;
    assign funds_in[0] = X_funds;
    assign funds_in[1] = Y_funds;
    assign funds_in[2] = Z_funds;
    assign valid_in    = {Z_valid, Y_valid, X_valid};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (round_end) state_d = StCapture;
            StCapture: state_d = StCompare;
            StCompare: state_d = StSettle;
            StSettle:  state_d = StReport;
            StReport:  if (res_ack) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        elig_d = '0;
        for (int i = 0; i < 3; i++) begin
            elig_d[i] = vld_q[i] && (BAL_W'(bid_q[i]) <= fund_q[i]);
        end
    end

    always_comb begin
        max_d = '0;
        any_d = 1'b0;
        hit_d = '0;
        cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (elig_q[i] && (!any_d || bid_q[i] > max_d)) begin
                max_d = bid_q[i];
                any_d = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (elig_q[i] && bid_q[i] == max_d) begin
                hit_d[i] = 1'b1;
                cnt_d    = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                bid_q[i]  <= '0;
                fund_q[i] <= '0;
                bal_q[i]  <= '0;
            end
            vld_q      <= '0;
            elig_q     <= '0;
            win1h_q    <= '0;
            max_q      <= '0;
            tie_q      <= 1'b0;
            none_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ovr_pend_q <= 1'b0;
            win_q      <= '0;
            max_bid_q  <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (round_end) begin
                        for (int i = 0; i < 3; i++) begin
                            bid_q[i]  <= curr_in[i];
                            fund_q[i] <= funds_in[i];
                        end
                        vld_q      <= valid_in;
                        win_q      <= '0;
                        err_q      <= '0;
                        ovr_q      <= ovr_pend_q;
                        ovr_pend_q <= 1'b0;
                    end
                end
                StCapture: begin
                    elig_q <= elig_d;
                    if (round_end) ovr_q <= 1'b1;
                end
                StCompare: begin
                    max_q   <= max_d;
                    win1h_q <= (cnt_d == 2'd1) ? hit_d : 3'b000;
                    tie_q   <= (cnt_d >= 2'd2);
                    none_q  <= !any_d;
                    if (round_end) ovr_q <= 1'b1;
                end
                StSettle: begin
                    for (int i = 0; i < 3; i++) begin
                        bal_q[i] <= win1h_q[i] ? (fund_q[i] - BAL_W'(max_q)) : fund_q[i];
                    end
                    win_q     <= win1h_q;
                    max_bid_q <= (|win1h_q) ? BAL_W'(max_q) : '0;
                    if (ovr_q || round_end) begin
                        err_q <= 2'b11;
                    end else if (none_q) begin
                        err_q <= 2'b10;
                    end else if (tie_q) begin
                        err_q <= 2'b01;
                    end else begin
                        err_q <= 2'b00;
                    end
                end
                StReport: begin
                    if (round_end) ovr_pend_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign X_win     = win_q[0];
    assign Y_win     = win_q[1];
    assign Z_win     = win_q[2];
    assign X_balance = bal_q[0];
    assign Y_balance = bal_q[1];
    assign Z_balance = bal_q[2];
    assign maxBid    = max_bid_q;
    assign err       = err_q;
    assign roundOver = (state_q == StReport);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bids22_settle.sv
// Self-checking bench for bids22_settle: directed vector table, handshake/overrun sequences
// and randomized rounds checked against a behavioural auction model.
module tb_bids22_settle;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        round_end = 1'b0;
    logic [15:0] X_curr = '0, Y_curr = '0, Z_curr = '0;
    logic        X_valid = 1'b0, Y_valid = 1'b0, Z_valid = 1'b0;
    logic [31:0] X_funds = '0, Y_funds = '0, Z_funds = '0;
    logic        res_ack = 1'b0;
    logic        X_win, Y_win, Z_win;
    logic [31:0] X_balance, Y_balance, Z_balance, maxBid;
    logic        roundOver;
    logic [1:0]  err;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    bids22_settle #(.BID_W(16), .BAL_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .round_end(round_end),
        .X_curr(X_curr), .Y_curr(Y_curr), .Z_curr(Z_curr),
        .X_valid(X_valid), .Y_valid(Y_valid), .Z_valid(Z_valid),
        .X_funds(X_funds), .Y_funds(Y_funds), .Z_funds(Z_funds),
        .res_ack(res_ack),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
        .X_balance(X_balance), .Y_balance(Y_balance), .Z_balance(Z_balance),
        .maxBid(maxBid), .roundOver(roundOver), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0][15:0] c;
        logic [2:0]       v;
        logic [2:0][31:0] f;
    } vec_t;

    typedef struct {
        logic [2:0]       w;
        logic [2:0][31:0] b;
        logic [31:0]      m;
        logic [1:0]       e;
    } exp_t;

    typedef struct {
        vec_t in;
        exp_t ex;
    } rec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic chk_res(input string tag, input exp_t e);
        chk({tag, ".win"}, {61'd0, Z_win, Y_win, X_win}, {61'd0, e.w});
        chk({tag, ".xbal"}, {32'd0, X_balance}, {32'd0, e.b[0]});
        chk({tag, ".ybal"}, {32'd0, Y_balance}, {32'd0, e.b[1]});
        chk({tag, ".zbal"}, {32'd0, Z_balance}, {32'd0, e.b[2]});
        chk({tag, ".maxbid"}, {32'd0, maxBid}, {32'd0, e.m});
        chk({tag, ".err"}, {62'd0, err}, {62'd0, e.e});
    endtask

    // Auction rules: an eligible bidder is valid and can afford its bid; a unique top bid wins.
    function automatic exp_t model(input vec_t v, input bit ovr);
        exp_t r;
        longint best = -1;
        int n_top = 0;
        int who = 0;
        r.w = '0;
        r.b = v.f;
        r.m = '0;
        for (int i = 0; i < 3; i++)
            if (v.v[i] && v.c[i] <= v.f[i] && longint'(v.c[i]) > best) best = longint'(v.c[i]);
        for (int i = 0; i < 3; i++)
            if (v.v[i] && v.c[i] <= v.f[i] && longint'(v.c[i]) == best) begin
                n_top++;
                who = i;
            end
        if (n_top == 0) r.e = 2'b10;
        else if (n_top > 1) r.e = 2'b01;
        else begin
            r.e = 2'b00;
            r.w[who] = 1'b1;
            r.m = 32'(best);
            r.b[who] = v.f[who] - 32'(best);
        end
        if (ovr) r.e = 2'b11;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        {Z_curr, Y_curr, X_curr} = v.c;
        {Z_valid, Y_valid, X_valid} = v.v;
        {Z_funds, Y_funds, X_funds} = v.f;
    endtask

    task automatic scramble();
        X_curr = 16'($urandom); Y_curr = 16'($urandom); Z_curr = 16'($urandom);
        X_funds = $urandom; Y_funds = $urandom; Z_funds = $urandom;
        {Z_valid, Y_valid, X_valid} = 3'($urandom);
    endtask

    // Pulse round_end in IDLE; return at the negedge of the CAPTURE cycle with inputs scrambled.
    task automatic launch(input vec_t v);
        @(negedge clk);
        drive(v);
        round_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        round_end = 1'b0;
        scramble();
    endtask

    // From CAPTURE, optionally pulse round_end during COMPARE, then check roundOver timing.
    task automatic to_report(input string tag, input bit inject);
        res_ack = 1'b1;  // ignored outside REPORT
        @(posedge clk);
        @(negedge clk);
        if (inject) round_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        round_end = 1'b0;
        res_ack = 1'b0;
        chk({tag, ".ro_early"}, {63'd0, roundOver}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ro_n4"}, {63'd0, roundOver}, 64'd1);
    endtask

    task automatic ack(input string tag);
        res_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ack = 1'b0;
        chk({tag, ".ro_drop"}, {62'd0, roundOver, busy}, 64'd0);
    endtask

    rec_t tbl [8];
    vec_t vr;
    exp_t er, prev;

    initial begin
        tbl[0] = '{in: '{c: {16'd90, 16'd250, 16'd100}, v: 3'b111,
                         f: {32'd1000, 32'd300, 32'd500}},
                   ex: '{w: 3'b010, b: {32'd1000, 32'd50, 32'd500}, m: 32'd250, e: 2'b00}};
        tbl[1] = '{in: '{c: {16'd150, 16'd200, 16'd200}, v: 3'b111,
                         f: {32'd400, 32'd300, 32'd500}},
                   ex: '{w: 3'b000, b: {32'd400, 32'd300, 32'd500}, m: 32'd0, e: 2'b01}};
        tbl[2] = '{in: '{c: {16'd400, 16'd999, 16'd50}, v: 3'b101,
                         f: {32'd300, 32'd1000, 32'd200}},
                   ex: '{w: 3'b001, b: {32'd300, 32'd1000, 32'd150}, m: 32'd50, e: 2'b00}};
        tbl[3] = '{in: '{c: {16'd5, 16'd6, 16'd7}, v: 3'b000,
                         f: {32'd10, 32'd20, 32'd30}},
                   ex: '{w: 3'b000, b: {32'd10, 32'd20, 32'd30}, m: 32'd0, e: 2'b10}};
        tbl[4] = '{in: '{c: {16'd3, 16'd9, 16'd0}, v: 3'b001,
                         f: {32'd8, 32'd9, 32'd7}},
                   ex: '{w: 3'b001, b: {32'd8, 32'd9, 32'd7}, m: 32'd0, e: 2'b00}};
        tbl[5] = '{in: '{c: {16'd0, 16'hFFFF, 16'd10}, v: 3'b011,
                         f: {32'd0, 32'h0000FFFF, 32'd100}},
                   ex: '{w: 3'b010, b: {32'd0, 32'd0, 32'd100}, m: 32'h0000FFFF, e: 2'b00}};
        tbl[6] = '{in: '{c: {16'd31, 16'd21, 16'd11}, v: 3'b111,
                         f: {32'd30, 32'd20, 32'd10}},
                   ex: '{w: 3'b000, b: {32'd30, 32'd20, 32'd10}, m: 32'd0, e: 2'b10}};
        tbl[7] = '{in: '{c: {16'd0, 16'd0, 16'd0}, v: 3'b111,
                         f: {32'd1, 32'd2, 32'd3}},
                   ex: '{w: 3'b000, b: {32'd1, 32'd2, 32'd3}, m: 32'd0, e: 2'b01}};

        #12;
        chk("reset.ro_busy", {62'd0, roundOver, busy}, 64'd0);
        chk_res("reset", '{w: 3'b000, b: '0, m: 32'd0, e: 2'b00});
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            launch(tbl[i].in);
            to_report(tag, 1'b0);
            chk_res(tag, tbl[i].ex);
            ack(tag);
            chk_res({tag, ".persist"}, tbl[i].ex);
        end

        // Result held while host withholds ack.
        launch(tbl[3].in);
        to_report("hold", 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("hold.ro%0d", k), {63'd0, roundOver}, 64'd1);
        end
        chk_res("hold", tbl[3].ex);
        ack("hold");

        // Reset while SETTLE is in progress with X winning.
        launch(tbl[2].in);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_settle.ro_busy", {62'd0, roundOver, busy}, 64'd0);
        chk_res("rst_settle", '{w: 3'b000, b: '0, m: 32'd0, e: 2'b00});
        @(negedge clk);
        reset_n = 1'b1;
        launch(tbl[0].in);
        to_report("post_rst", 1'b0);
        chk_res("post_rst", tbl[0].ex);
        ack("post_rst");

        // Overrun: second round_end during COMPARE keeps original result, err forced to 11.
        launch(tbl[2].in);
        to_report("ovr_cmp", 1'b1);
        er = tbl[2].ex;
        er.e = 2'b11;
        chk_res("ovr_cmp", er);
        ack("ovr_cmp");
        launch(tbl[0].in);
        to_report("ovr_clr", 1'b0);
        chk_res("ovr_clr", tbl[0].ex);

        // round_end together with res_ack in REPORT: ack wins, next round flagged overrun.
        @(negedge clk);
        round_end = 1'b1;
        res_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        round_end = 1'b0;
        res_ack = 1'b0;
        chk("rep_both.ro_busy", {62'd0, roundOver, busy}, 64'd0);
        launch(tbl[5].in);
        to_report("rep_next", 1'b0);
        er = tbl[5].ex;
        er.e = 2'b11;
        chk_res("rep_next", er);
        ack("rep_next");
        launch(tbl[5].in);
        to_report("rep_clr", 1'b0);
        chk_res("rep_clr", tbl[5].ex);
        ack("rep_clr");

        for (int r = 0; r < 40; r++) begin
            string tag;
            tag = $sformatf("rnd%0d", r);
            for (int i = 0; i < 3; i++) begin
                if (r % 4 == 3) begin
                    vr.c[i] = 16'($urandom);
                    vr.f[i] = 32'($urandom_range(0, 70000));
                end else begin
                    vr.c[i] = 16'($urandom_range(0, 12));
                    vr.f[i] = 32'($urandom_range(0, 15));
                end
            end
            vr.v = 3'($urandom);
            launch(vr);
            to_report(tag, 1'b0);
            er = model(vr, 1'b0);
            chk_res(tag, er);
            ack(tag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
